xw_arbiter: RTL and testbench

XW_ARBITER -- requirements
Module: xw_arbiter

---
 rtl/xw_arbiter.sv | 131 +++++++++++++
 tb/tb_xw_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xw_arbiter.sv
// xw_arbiter
//   Round-robin writeback arbiter: several execute units share one
//   writeback port through a single registered output entry.
//   Optional macro XW_ARBITER_FIXED_PRIO_EN selects fixed priority
//   (lowest valid index wins, no priority pointer).
// Ports
//   clk, rst                 clock, async active-low reset
//   X_val/X_rdy              per-unit handshake
//   X_pc/X_seq_num/X_waddr/X_wdata/X_wen   per-unit payload
//   W_val/W_rdy              writeback handshake
//   W_pc/W_seq_num/W_waddr/W_wdata/W_wen   writeback payload (registered)
module xw_arbiter #(
   parameter int p_num_units    = 2,
   parameter int p_seq_num_bits = 5
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [p_num_units-1:0]                         X_val,
   output logic [p_num_units-1:0]                         X_rdy,
   input  logic [p_num_units-1:0][31:0]                   X_pc,
   input  logic [p_num_units-1:0][p_seq_num_bits-1:0]     X_seq_num,
   input  logic [p_num_units-1:0][4:0]                    X_waddr,
   input  logic [p_num_units-1:0][31:0]                   X_wdata,
   input  logic [p_num_units-1:0]                         X_wen,
   output logic                                           W_val,
   input  logic                                           W_rdy,
   output logic [31:0]                                    W_pc,
   output logic [p_seq_num_bits-1:0]                      W_seq_num,
   output logic [4:0]                                     W_waddr,
   output logic [31:0]                                    W_wdata,
   output logic                                           W_wen
);

   localparam int PW = (p_num_units > 1) ? $clog2(p_num_units) : 1;

   typedef struct packed {
      logic                      val;
      logic [31:0]               pc;
      logic [p_seq_num_bits-1:0] seq;
      logic [4:0]                waddr;
      logic [31:0]               wdata;
      logic                      wen;
   } entry_t;

   entry_t          entry_q, entry_d;
   logic            w_xfer, slot_free;
   logic            gnt_any, gnt;
   logic [PW-1:0]   gnt_idx;

   assign w_xfer    = entry_q.val & W_rdy;
   assign slot_free = ~entry_q.val | w_xfer;

`ifdef XW_ARBITER_FIXED_PRIO_EN
   // Descending scan so the lowest valid index is the last (winning) write.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = p_num_units - 1; i >= 0; i--) begin
         if (X_val[i]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] rr_idx;

   // Search ptr, ptr+1, ... wrapping; first valid unit wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      rr_idx  = '0;
      for (int i = 0; i < p_num_units; i++) begin
         rr_idx = PW'((int'(ptr_q) + i) % p_num_units);
         if (!gnt_any && X_val[rr_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt) ptr_d = (gnt_idx == PW'(p_num_units - 1)) ? '0 : gnt_idx + PW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end
`endif

   // Gating with rst keeps X_rdy low for the whole time reset is held,
   // even though an empty entry would otherwise look free.
   assign gnt = gnt_any & slot_free & rst;

   always_comb begin
      X_rdy = '0;
      if (gnt) X_rdy[gnt_idx] = 1'b1;
   end

   // A grant on the same edge as a writeback replaces the entry, so a
   // steady stream moves one result per cycle with no bubble.
   always_comb begin
      entry_d = entry_q;
      if (gnt) begin
         entry_d.val   = 1'b1;
         entry_d.pc    = X_pc[gnt_idx];
         entry_d.seq   = X_seq_num[gnt_idx];
         entry_d.waddr = X_waddr[gnt_idx];
         entry_d.wdata = X_wdata[gnt_idx];
         entry_d.wen   = X_wen[gnt_idx];
      end else if (w_xfer) begin
         entry_d.val   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) entry_q <= '0;
      else      entry_q <= entry_d;
   end

   assign W_val     = entry_q.val;
   assign W_pc      = entry_q.pc;
   assign W_seq_num = entry_q.seq;
   assign W_waddr   = entry_q.waddr;
   assign W_wdata   = entry_q.wdata;
   assign W_wen     = entry_q.wen;

endmodule

// File: tb/tb_xw_arbiter.sv
module tb_xw_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // two-unit instance
   logic [1:0]       x_val, x_rdy, x_wen;
   logic [1:0][31:0] x_pc, x_wdata;
   logic [1:0][4:0]  x_seq, x_waddr;
   logic             xw_val, xw_rdy, xw_wen;
   logic [31:0]      xw_pc, xw_wdata;
   logic [4:0]       xw_seq, xw_waddr;

   // four-unit instance
   logic [3:0]       y_val, y_rdy, y_wen;
   logic [3:0][31:0] y_pc, y_wdata;
   logic [3:0][4:0]  y_seq, y_waddr;
   logic             yw_val, yw_rdy, yw_wen;
   logic [31:0]      yw_pc, yw_wdata;
   logic [4:0]       yw_seq, yw_waddr;

   xw_arbiter #(.p_num_units(2), .p_seq_num_bits(5)) u2 (
      .clk(clk), .rst(rst),
      .X_val(x_val), .X_rdy(x_rdy), .X_pc(x_pc), .X_seq_num(x_seq),
      .X_waddr(x_waddr), .X_wdata(x_wdata), .X_wen(x_wen),
      .W_val(xw_val), .W_rdy(xw_rdy), .W_pc(xw_pc), .W_seq_num(xw_seq),
      .W_waddr(xw_waddr), .W_wdata(xw_wdata), .W_wen(xw_wen));

   xw_arbiter #(.p_num_units(4), .p_seq_num_bits(5)) u4 (
      .clk(clk), .rst(rst),
      .X_val(y_val), .X_rdy(y_rdy), .X_pc(y_pc), .X_seq_num(y_seq),
      .X_waddr(y_waddr), .X_wdata(y_wdata), .X_wen(y_wen),
      .W_val(yw_val), .W_rdy(yw_rdy), .W_pc(yw_pc), .W_seq_num(yw_seq),
      .W_waddr(yw_waddr), .W_wdata(yw_wdata), .W_wen(yw_wen));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      x_val = 2'b11; xw_rdy = 1'b1;
      y_val = 4'b1111; yw_rdy = 1'b1;
      x_pc = {32'h1000_0004, 32'h1000_0000};
      x_seq = {5'd1, 5'd0};
      x_waddr = {5'd11, 5'd10};
      x_wdata = {32'hB1, 32'hA0};
      x_wen = 2'b10;
      for (int i = 0; i < 4; i++) begin
         y_pc[i] = 32'h2000_0000 + 32'(i);
         y_seq[i] = 5'(i);
         y_waddr[i] = 5'(i);
         y_wdata[i] = 32'hC0 + 32'(i);
         y_wen[i] = 1'b1;
      end
      step; step;
      checks++;
      if (x_rdy !== 2'b00 || xw_val !== 1'b0) begin
         errors++;
         $display("FAIL reset_u2: x_rdy=%b w_val=%b, want 00/0", x_rdy, xw_val);
      end
      checks++;
      if (y_rdy !== 4'b0000 || yw_val !== 1'b0) begin
         errors++;
         $display("FAIL reset_u4: y_rdy=%b w_val=%b, want 0000/0", y_rdy, yw_val);
      end
      x_val = 2'b00; y_val = 4'b0000;
      rst = 1'b1;
      step;
   endtask

   // Both units valid every cycle; round-robin alternates 0,1,0,1.
   task automatic test_alternate;
      logic [1:0]  exp_rdy;
      logic [1:0]  prev_rdy;
      logic [31:0] exp_data;
      x_val = 2'b11; xw_rdy = 1'b1;
      prev_rdy = 2'b00;
      for (int k = 0; k < 6; k++) begin
         #2;
`ifdef XW_ARBITER_FIXED_PRIO_EN
         exp_rdy = 2'b01;
`else
         exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
         checks++;
         if (x_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL alt_grant[%0d]: x_rdy=%b, want %b", k, x_rdy, exp_rdy);
         end
         if (k == 0) begin
            checks++;
            if (xw_val !== 1'b0) begin
               errors++;
               $display("FAIL alt_first_wval: w_val=%b, want 0", xw_val);
            end
         end else begin
            exp_data = (prev_rdy == 2'b01) ? 32'hA0 : 32'hB1;
            checks++;
            if (xw_val !== 1'b1 || xw_wdata !== exp_data) begin
               errors++;
               $display("FAIL alt_wb[%0d]: w_val=%b wdata=%h, want 1/%h", k, xw_val, xw_wdata, exp_data);
            end
         end
         prev_rdy = exp_rdy;
         step;
      end
      x_val = 2'b00;
      step;
   endtask

   // Held entry stays stable through a 3-cycle stall.
   task automatic test_stall;
      x_val = 2'b01; xw_rdy = 1'b0;
      x_wdata[0] = 32'h0000_0005; x_waddr[0] = 5'd3;
      #2;
      checks++;
      if (x_rdy !== 2'b01) begin
         errors++;
         $display("FAIL stall_grant: x_rdy=%b, want 01", x_rdy);
      end
      step;
      x_wdata[0] = 32'h0000_0007; x_waddr[0] = 5'd4;
      for (int k = 0; k < 3; k++) begin
         #2;
         checks++;
         if (x_rdy !== 2'b00 || xw_val !== 1'b1 || xw_wdata !== 32'h5 || xw_waddr !== 5'd3) begin
            errors++;
            $display("FAIL stall_hold[%0d]: rdy=%b val=%b wdata=%h waddr=%0d, want 00/1/5/3",
                     k, x_rdy, xw_val, xw_wdata, xw_waddr);
         end
         step;
      end
      xw_rdy = 1'b1;
      #2;
      checks++;
      if (x_rdy !== 2'b01) begin
         errors++;
         $display("FAIL stall_release: x_rdy=%b, want 01", x_rdy);
      end
      step;
      checks++;
      if (xw_val !== 1'b1 || xw_wdata !== 32'h7 || xw_waddr !== 5'd4) begin
         errors++;
         $display("FAIL stall_next: val=%b wdata=%h waddr=%0d, want 1/7/4", xw_val, xw_wdata, xw_waddr);
      end
      x_val = 2'b00;
   endtask

   // Entry replaced on the same edge as writeback: no bubble, no loss.
   task automatic test_back_to_back;
      logic [4:0] s;
      x_val = 2'b10; xw_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s = 5'd10 + 5'(k);
         x_seq[1] = s;
         #2;
         checks++;
         if (x_rdy !== 2'b10) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: x_rdy=%b, want 10", k, x_rdy);
         end
         step;
         checks++;
         if (xw_val !== 1'b1 || xw_seq !== s || xw_wen !== 1'b1) begin
            errors++;
            $display("FAIL b2b_seq[%0d]: val=%b seq=%0d wen=%b, want 1/%0d/1", k, xw_val, xw_seq, xw_wen, s);
         end
      end
      x_val = 2'b00;
      #2;
      checks++;
      if (x_rdy !== 2'b00) begin
         errors++;
         $display("FAIL b2b_idle_rdy: x_rdy=%b, want 00", x_rdy);
      end
      step;
      checks++;
      if (xw_val !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: w_val=%b, want 0", xw_val);
      end
   endtask

   // Four units: pointer wrap and skip.
   task automatic test_rr4;
      logic [3:0] vals [5];
      logic [3:0] exp_rdy [5];
      logic [4:0] exp_addr;
      vals[0] = 4'b0010; exp_rdy[0] = 4'b0010;
      vals[1] = 4'b1000; exp_rdy[1] = 4'b1000;
      vals[2] = 4'b1111; exp_rdy[2] = 4'b0001;
`ifdef XW_ARBITER_FIXED_PRIO_EN
      vals[3] = 4'b1001; exp_rdy[3] = 4'b0001;
`else
      vals[3] = 4'b1001; exp_rdy[3] = 4'b1000;
`endif
      vals[4] = 4'b0000; exp_rdy[4] = 4'b0000;
      yw_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         y_val = vals[k];
         #2;
         checks++;
         if (y_rdy !== exp_rdy[k]) begin
            errors++;
            $display("FAIL rr4_grant[%0d]: y_rdy=%b, want %b", k, y_rdy, exp_rdy[k]);
         end
         step;
         exp_addr = 5'd0;
         for (int i = 0; i < 4; i++) if (exp_rdy[k][i]) exp_addr = 5'(i);
         checks++;
         if (yw_val !== (exp_rdy[k] != 4'b0000) || (yw_val && yw_waddr !== exp_addr)) begin
            errors++;
            $display("FAIL rr4_wb[%0d]: val=%b waddr=%0d, want %b/%0d",
                     k, yw_val, yw_waddr, (exp_rdy[k] != 4'b0000), exp_addr);
         end
      end
   endtask

   // Reset while stalled discards the entry; first grant after uses ptr 0.
   task automatic test_reset_mid;
      x_val = 2'b10; xw_rdy = 1'b0;
      x_wdata[0] = 32'hA0;
      step;
      x_val = 2'b11;
      #2;
      checks++;
      if (xw_val !== 1'b1 || x_rdy !== 2'b00) begin
         errors++;
         $display("FAIL rmid_pre: val=%b rdy=%b, want 1/00", xw_val, x_rdy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (xw_val !== 1'b0 || x_rdy !== 2'b00) begin
         errors++;
         $display("FAIL rmid_async: val=%b rdy=%b, want 0/00", xw_val, x_rdy);
      end
      step;
      rst = 1'b1; xw_rdy = 1'b1;
      #2;
      checks++;
      if (x_rdy !== 2'b01) begin
         errors++;
         $display("FAIL rmid_first_grant: x_rdy=%b, want 01", x_rdy);
      end
      step;
      checks++;
      if (xw_val !== 1'b1 || xw_wdata !== 32'hA0) begin
         errors++;
         $display("FAIL rmid_wb: val=%b wdata=%h, want 1/a0", xw_val, xw_wdata);
      end
      x_val = 2'b00;
      step;
   endtask

   initial begin
      test_reset;
      test_alternate;
      test_stall;
      test_back_to_back;
      test_rr4;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
